// File: rtl/irq_pkg.sv
// irq_pkg: register map, CTRL bit positions and FSM state encoding shared by
// the interrupt controller and its sub-modules.
package irq_pkg;

  // Byte offsets of the four register words within the block.
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_PEND  = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h8;
  localparam logic [3:0] OFF_EOI   = 4'hC;

  // CTRL global interrupt enable; CAUSE in-service flag shares the bit.
  localparam int unsigned CTRL_GIE_BIT   = 31;
  localparam int unsigned CAUSE_SVC_BIT  = 31;

  // cause is always reported on 3 bits regardless of source count.
  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
// valid_o is high when any request bit is set; idx_o is 0 otherwise.
module irq_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan upward and keep only the first set bit.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !valid_o) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller driving the CPU IRQ line.
// Latches peripheral requests into PEND, resolves priority among enabled
// sources and sequences IDLE -> ASSERT -> SERVICE -> RETURN around the CPU's
// kernel entry, EOI write and return to user mode.
// Build option: define IRQ_LEVEL_EN for level-sensitive capture (PEND set
// while src is high; W1C and EOI clear only bits whose src is low).
// Default build uses rising-edge capture.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             pc31,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq,
  output logic [2:0]       cause
);

  irq_state_e           state_q;
  logic                 gie_q;
  logic [N_SRC-1:0]     mask_q;
  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     src_q;
  logic                 pc31_q;
  logic                 irq_q;
  logic [CAUSE_W-1:0]   cause_q;

  logic                 wr_en, wr_ctrl, wr_pend, wr_eoi;
  logic [N_SRC-1:0]     pend_set, w1c_clr, eoi_clr;
  logic [N_SRC-1:0]     elig;
  logic [MAX_SRC-1:0]   elig_ext;
  logic [MAX_SRC-1:0]   cause_onehot;
  logic [CAUSE_W-1:0]   win_idx;
  logic                 win_v;
  logic                 unused_bits;

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en   = wr & hit;
  assign wr_ctrl = wr_en && (addr[3:2] == OFF_CTRL[3:2]);
  assign wr_pend = wr_en && (addr[3:2] == OFF_PEND[3:2]);
  assign wr_eoi  = wr_en && (addr[3:2] == OFF_EOI[3:2]);

  assign unused_bits = ^{addr[1:0], wdata[30:N_SRC]};

  assign irq   = irq_q;
  assign cause = cause_q;

  // Capture, clear and eligibility terms; set is OR'd last so it wins.
  always_comb begin
    cause_onehot = MAX_SRC'(1) << cause_q;
`ifdef IRQ_LEVEL_EN
    pend_set = src;
    w1c_clr  = wr_pend ? (wdata[N_SRC-1:0] & ~src) : '0;
    eoi_clr  = (wr_eoi && state_q == SERVICE) ? (cause_onehot[N_SRC-1:0] & ~src) : '0;
`else
    pend_set = src & ~src_q;
    w1c_clr  = wr_pend ? wdata[N_SRC-1:0] : '0;
    eoi_clr  = (wr_eoi && state_q == SERVICE) ? cause_onehot[N_SRC-1:0] : '0;
`endif
    pend_d   = (pend_q & ~(w1c_clr | eoi_clr)) | pend_set;
    elig     = gie_q ? (pend_q & mask_q) : '0;
    elig_ext = '0;
    elig_ext[N_SRC-1:0] = elig;
  end

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (CAUSE_W)
  ) u_prio (
    .req_i   (elig),
    .idx_o   (win_idx),
    .valid_o (win_v)
  );

  // CTRL, PEND and the one-cycle history of src and pc31.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gie_q  <= 1'b0;
      mask_q <= '0;
      pend_q <= '0;
      src_q  <= '0;
      pc31_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        gie_q  <= wdata[CTRL_GIE_BIT];
        mask_q <= wdata[N_SRC-1:0];
      end
      pend_q <= pend_d;
      src_q  <= src;
      pc31_q <= pc31;
    end
  end

  // Request sequencing with registered irq and cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_v) begin
            cause_q <= win_idx;
            irq_q   <= 1'b1;
            state_q <= ASSERT;
          end
        end
        ASSERT: begin
          if (pc31 && !pc31_q) begin
            irq_q   <= 1'b0;
            state_q <= SERVICE;
          end else if (!elig_ext[cause_q]) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (wr_eoi) state_q <= RETURN;
        end
        RETURN: begin
          if (!pc31) state_q <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency register read mux; zero when not selected.
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      unique case (addr[3:2])
        OFF_CTRL[3:2]: begin
          rdata[CTRL_GIE_BIT] = gie_q;
          rdata[N_SRC-1:0]    = mask_q;
        end
        OFF_PEND[3:2]: begin
          rdata[N_SRC-1:0] = pend_q;
        end
        OFF_CAUSE[3:2]: begin
          rdata[CAUSE_SVC_BIT] = (state_q == SERVICE);
          rdata[CAUSE_W-1:0]   = cause_q;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected values; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h4000_0030;
  localparam logic [3:0]  O_CTRL  = 4'h0;
  localparam logic [3:0]  O_PEND  = 4'h4;
  localparam logic [3:0]  O_CAUSE = 4'h8;
  localparam logic [3:0]  O_EOI   = 4'hC;

  localparam int K_RD    = 0;
  localparam int K_RAW   = 1;
  localparam int K_IRQ   = 2;
  localparam int K_CAUSE = 3;
  localparam int K_HIT   = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  src;
  logic        pc31;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;
  logic [2:0]  cause;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  irq_controller #(
    .N_SRC     (4),
    .BASE_ADDR (32'h4000_0030)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .pc31  (pc31),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq),
    .cause (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain every expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD, K_RAW: act = rdata;
        K_IRQ:       act = {31'b0, irq};
        K_CAUSE:     act = {29'b0, cause};
        default:     act = {31'b0, hit};
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic push(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] d);
    wr    = 1'b1;
    addr  = BASE + 32'(off);
    wdata = d;
    cyc();
  endtask

  task automatic ck_rd(input logic [3:0] off, input logic [31:0] v, input string n);
    rd   = 1'b1;
    addr = BASE + 32'(off);
    push(n, K_RD, v);
  endtask

  initial begin
    reset = 1'b0; src = '0; pc31 = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    // Reset state
    cyc();
    ck_rd(O_CTRL, 32'h0, "rst_ctrl"); push("rst_irq", K_IRQ, 0); push("rst_cause", K_CAUSE, 0);
    cyc();
    ck_rd(O_PEND, 32'h0, "rst_pend"); cyc();
    ck_rd(O_CAUSE, 32'h0, "rst_cause_rd"); cyc();
    reset = 1'b1;
    cyc();

    // Single request on src[1]
    wr_reg(O_CTRL, 32'h8000_0003);
    ck_rd(O_CTRL, 32'h8000_0003, "ctrl_rb"); cyc();
    addr = BASE; push("rd0_zero", K_RAW, 0); push("hit_base", K_HIT, 1); cyc();
    addr = 32'h4000_0040; push("hit_miss", K_HIT, 0); cyc();
    src = 4'b0010; cyc(); src = '0;
    ck_rd(O_PEND, 32'h2, "s1_pend"); push("s1_irq_pre", K_IRQ, 0); cyc();
    push("s1_irq", K_IRQ, 1); push("s1_cause", K_CAUSE, 1); ck_rd(O_CAUSE, 32'h1, "s1_cause_rd"); cyc();
    pc31 = 1'b1; cyc();
    push("s1_svc_irq", K_IRQ, 0); ck_rd(O_CAUSE, 32'h8000_0001, "s1_svc_cause"); cyc();
    wr_reg(O_EOI, 32'h0);
    ck_rd(O_PEND, 32'h0, "s1_eoi_pend"); push("s1_ret_irq", K_IRQ, 0); cyc();
    ck_rd(O_CAUSE, 32'h1, "s1_ret_cause"); cyc();
    pc31 = 1'b0; cyc();
    push("s1_idle_irq", K_IRQ, 0); cyc();

    // Simultaneous src[0] and src[1]
    src = 4'b0011; cyc(); src = '0; cyc();
    push("s2_irq", K_IRQ, 1); push("s2_cause0", K_CAUSE, 0); ck_rd(O_PEND, 32'h3, "s2_pend"); cyc();
    pc31 = 1'b1; cyc();
    wr_reg(O_EOI, 32'h0);
    ck_rd(O_PEND, 32'h2, "s2_eoi_pend"); push("s2_ret_irq", K_IRQ, 0); cyc();
    pc31 = 1'b0; cyc();
    push("s2_idle_irq", K_IRQ, 0); cyc();
    push("s2_irq2", K_IRQ, 1); push("s2_cause1", K_CAUSE, 1); cyc();
    pc31 = 1'b1; cyc();
    wr_reg(O_EOI, 32'h0);
    pc31 = 1'b0; cyc(); cyc();

    // Masked source, then enabled; W1C cancels an asserted request
    src = 4'b0100; cyc(); src = '0;
    ck_rd(O_PEND, 32'h4, "s3_pend"); push("s3_irq_masked", K_IRQ, 0); cyc();
    push("s3_irq_masked2", K_IRQ, 0); cyc();
    wr_reg(O_CTRL, 32'h8000_0007);
    push("s3_irq_pre", K_IRQ, 0); cyc();
    push("s3_irq", K_IRQ, 1); push("s3_cause", K_CAUSE, 2); cyc();
    wr_reg(O_PEND, 32'h4);
    ck_rd(O_PEND, 32'h0, "s3_w1c_pend"); push("s3_irq_hold", K_IRQ, 1); cyc();
    push("s3_cancel", K_IRQ, 0); cyc();

    // Set wins over W1C; EOI ignored in ASSERT
    src = 4'b0001; wr_reg(O_PEND, 32'h1); src = '0;
    ck_rd(O_PEND, 32'h1, "s4_set_wins"); cyc();
    push("s4_irq", K_IRQ, 1); push("s4_cause", K_CAUSE, 0); cyc();
    wr_reg(O_EOI, 32'h0);
    ck_rd(O_PEND, 32'h1, "s4_eoi_ign"); push("s4_irq_hold", K_IRQ, 1); cyc();
    pc31 = 1'b1; cyc();
    ck_rd(O_CAUSE, 32'h8000_0000, "s4_svc_cause"); cyc();

    // Edges accumulate during SERVICE; asynchronous reset clears everything
    src = 4'b1000; cyc(); src = '0;
    ck_rd(O_PEND, 32'h9, "s5_pend_acc"); push("s5_svc_irq", K_IRQ, 0); cyc();
    reset = 1'b0;
    ck_rd(O_CTRL, 32'h0, "s5_rst_ctrl"); push("s5_rst_irq", K_IRQ, 0); push("s5_rst_cause", K_CAUSE, 0); cyc();
    ck_rd(O_PEND, 32'h0, "s5_rst_pend"); cyc();
    ck_rd(O_CAUSE, 32'h0, "s5_rst_cause_rd"); cyc();
    pc31 = 1'b0; reset = 1'b1; cyc();
    src = 4'b0001; cyc(); src = '0; cyc();
    wr_reg(O_EOI, 32'h0);
    ck_rd(O_PEND, 32'h1, "s5_eoi_idle_ign"); push("s5_irq_gie0", K_IRQ, 0); cyc();
    ck_rd(O_CAUSE, 32'h0, "s5_cause_idle"); cyc();

    // Asynchronous irq drop while asserted
    wr_reg(O_CTRL, 32'h8000_0001);
    push("s6_irq_pre", K_IRQ, 0); cyc();
    push("s6_irq", K_IRQ, 1); cyc();
    reset = 1'b0;
    push("s6_async_irq", K_IRQ, 0); cyc();
    reset = 1'b1; cyc();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the peripheral bus; drives the single IRQ line into the CPU control unit.
- Latches N_SRC peripheral interrupt sources (timer, UART RX, UART TX, switch) and resolves priority.
- Holds IRQ until the CPU enters kernel mode (PC[31]=1), then tracks the in-service source until software writes EOI and returns to user mode.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); index 0 is highest priority.
- BASE_ADDR, 32'h4000_0030, byte address of register block; 4 words at offsets 0x0, 0x4, 0x8, 0xC.

Ports:
- clk  input  1  CPU clock.
- reset  input  1  asynchronous, active-low.
- src  input  N_SRC  per-source request, synchronous to clk.
- pc31  input  1  PC[31] of CPU; 1 = kernel mode.
- rd  input  1  bus read strobe (MemRd).
- wr  input  1  bus write strobe (MemWr).
- addr  input  32  bus byte address (ALU result).
- wdata  input  32  bus write data.
- rdata  output  32  read data; 0 when not selected or rd=0.
- hit  output  1  addr[31:4]==BASE_ADDR[31:4]; used by the peripheral read mux.
- irq  output  1  interrupt request to control unit.
- cause  output  3  index of latched/in-service source.

Behaviour:
- Registers:
  - 0x0 CTRL, R/W: bit31 = GIE, bits[N_SRC-1:0] = per-source mask.
  - 0x4 PEND, read; write-1-to-clear.
  - 0x8 CAUSE, read-only: bit31 = in_service, bits[2:0] = cause.
  - 0xC EOI, write any value.
  - Unused bits read 0.
- Write semantics: a write is effective at the clk edge when wr=1 and hit=1; wr with any other addr is ignored.
- Read semantics: rdata is combinational, zero latency.
- Reset values: CTRL=0, PEND=0, cause=0, state=IDLE, irq=0, rdata=0.
- Pending capture: src edge detected against a 1-cycle delayed copy; a rising edge sets PEND[i].
  - Set and W1C on the same bit in the same cycle: set wins.
- Eligible vector: E = PEND & mask, gated by GIE.
- Priority: winner = lowest set index of E.
- FSM (2-bit state):
  - IDLE: irq=0. If E!=0, latch cause=winner and go to ASSERT.
  - ASSERT: irq=1.
    - If pc31=1 and the previous-cycle pc31=0 (kernel entry), go to SERVICE.
    - Else if E[cause]=0 (masked or cleared while the CPU was already in kernel mode), go to IDLE. irq drops the next cycle.
    - While pc31=0, the CPU is guaranteed to take the exception at the next edge, so no bus write can intervene.
  - SERVICE: irq=0, in_service=1, cause frozen.
    - Write to EOI clears PEND[cause] and goes to RETURN.
    - New edges keep accumulating in PEND.
  - RETURN: irq=0. Waits for pc31=0 (jr $26 executed), then goes to IDLE.
    - Prevents re-entry into the handler before the CPU returns to user mode.
- EOI written in IDLE, ASSERT or RETURN: ignored.
- No nesting: higher-priority edges during SERVICE wait until IDLE.
- Reset mid-operation: all state cleared immediately (asynchronous); irq falls without a clk edge.
- cause width is fixed at 3; upper bits are 0 when N_SRC<8.

Optional Feature:
- Macro: IRQ_LEVEL_EN.
- Defined: PEND[i] is set every cycle src[i]=1 (level-sensitive). W1C only takes effect when src[i]=0, and EOI clears PEND[cause] only if src[cause]=0.
- Undefined: rising-edge capture as above.

Decomposition:
- Package irq_pkg: register offsets (OFF_CTRL, OFF_PEND, OFF_CAUSE, OFF_EOI), CTRL_GIE_BIT=31, state encoding IDLE/ASSERT/SERVICE/RETURN.
- Sub-module irq_prio_enc: combinational N_SRC-bit lowest-index priority encoder producing the index plus a valid flag.

Test Plan:
- Reset, write CTRL=32'h8000_0003, pulse src[1] for 1 cycle with pc31=0 -> PEND=0x2, irq=1 one cycle after the PEND set, cause=1.
- Continuing: raise pc31 -> state SERVICE, irq=0, CAUSE reads 32'h8000_0001. Write EOI -> PEND=0. Drop pc31 -> IDLE.
- src[0] and src[1] edges in the same cycle, both enabled -> cause=0. After EOI and pc31 low, the second request asserts irq with cause=1.
- src[2] edge with mask bit 2=0 -> PEND=0x4, irq stays 0. Later write CTRL bit2=1 -> irq=1, cause=2.
- PEND W1C of 0x1 in the same cycle as a src[0] rising edge -> PEND[0] remains 1.
- Drive reset low while in SERVICE -> irq=0, CTRL=0, PEND=0, CAUSE=0 immediately; EOI written after reset is released is ignored.
